mdu_seq: RTL
============

Name: mdu_seq

Overview:
- Iterative sequencer for RV32M multiply/divide in the execute stage.
- Captures operand A and the operand-B mux output on a start request, then runs a radix-2 shift-add or shift-subtract loop over XLEN cycles.
- Stalls the pipeline while running, then returns a single-cycle-valid result to the writeback path.
- Single-cycle ALU ops never enter this block; the decoder asserts start only for funct7=0000001 OP instructions.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, $clog2(XLEN)+1, iteration counter width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only in IDLE
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- opa  input  XLEN  rs1 operand
- opb  input  XLEN  operand B, from the operand-B mux output (rs2_data when opb_sel=0)
- flush  input  1  abort current op (branch mispredict/trap)
- busy  output  1  high in CALC and FIX
- stall  output  1  pipeline hold request
- valid  output  1  one-cycle result strobe
- result  output  XLEN  result; held stable until next valid

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=IDLE, busy=0, stall=0, valid=0, result=0, counter=0.
- State encoding is free; there are four states.
  - IDLE: on start=1 and flush=0, latch funct3 and the operands.
    - For signed operands, latch absolute values and record the result sign.
    - MULHSU: only opa is signed.
    - Quotient sign = sign(opa) XOR sign(opb). Remainder sign = sign(opa).
    - Go to CALC with counter=XLEN.
  - CALC: one iteration per cycle; counter decrements; go to FIX when counter reaches 1.
    - Multiply: 2*XLEN-bit product accumulator.
    - Divide: restoring division; quotient and remainder registers are each XLEN bits.
  - FIX: apply two's-complement sign correction. Select product[XLEN-1:0] (MUL) or product[2XLEN-1:XLEN] (MULH*). Select quotient or remainder. Go to DONE.
  - DONE: valid=1 and result updated for exactly this cycle; go to IDLE.
- Latency: valid is high in the cycle XLEN+2 clocks after the start-sampled edge, i.e. 34 cycles at XLEN=32. Back-to-back starts are allowed: start in DONE is ignored, and start in the following IDLE cycle is accepted.
- stall = (state==IDLE & start & ~flush) | busy. It deasserts in DONE, so the pipeline advances and captures result together with valid.
- Divide by zero is a fast path: IDLE→DONE directly, valid one cycle after start.
  - Quotient = all ones.
  - Remainder = opa unmodified.
- Signed overflow (DIV/REM with opa=0x80000000, opb=0xFFFFFFFF) is a fast path: IDLE→DONE.
  - Quotient = 0x80000000.
  - Remainder = 0.
- flush has priority over everything except rst. In any state, flush=1 forces IDLE on the next edge, with no valid and busy=0. A start coincident with flush in IDLE is dropped.
- start while busy is ignored and does not affect the running op.
- rst mid-operation returns to the reset values on the next edge, with no valid.
- opa/opb/funct3 may change after the start cycle without effect.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: in IDLE, a MUL* op with opa==0 or opb==0 takes the IDLE→DONE fast path with result=0, valid one cycle after start. DIV/DIVU with |opa| < |opb| (nonzero opb) also takes the fast path with quotient 0 and remainder = opa.
- Undefined: these cases run the full XLEN+2 cycle sequence and produce identical results.
- The fast-path stall rule is the same as for divide by zero: stall is high only in the start cycle.

Test Plan:
- MUL opa=7, opb=0xFFFFFFFA (-6) → valid exactly 34 cycles after start; result=0xFFFFFFD6; stall high in cycles 0..33.
- MULH opa=0x80000000, opb=0x80000000 → result=0x40000000. MULHU opa=0xFFFFFFFF, opb=0xFFFFFFFF → result=0xFFFFFFFE. MULHSU opa=0xFFFFFFFF, opb=2 → result=0xFFFFFFFF.
- DIV opa=-7, opb=2 → result=0xFFFFFFFD. REM → result=0xFFFFFFFF. DIVU opa=100, opb=7 → result=14. REMU → result=2.
- DIVU x/0 with opa=0x1234 → valid 1 cycle later, result=0xFFFFFFFF. REM x/0 → result=0x1234. DIV 0x80000000/-1 → result=0x80000000. REM of the same → result=0.
- Start a MUL, assert flush at cycle 10 → IDLE next cycle, no valid ever, busy=0. Repeat with rst instead of flush at cycle 10 → same outcome, result=0.
- Start asserted continuously across two DIVU ops → second op accepted in the IDLE cycle after DONE; start pulses during CALC are ignored; two valid strobes total, each with a correct result.

Source files
------------

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module   : mdu_seq
// Brief    : Iterative RV32M multiply/divide sequencer (radix-2 shift-add /
//            restoring shift-subtract). Optional macro: MDU_EARLY_OUT_EN.
// Revision : 1.0
// ============================================================================
module mdu_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_CALC = 2'd1;
  localparam logic [1:0] C_FIX  = 2'd2;
  localparam logic [1:0] C_DONE = 2'd3;

  localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_div;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg;
  logic [XLEN-1:0]   r_result;

  // ---- operand conditioning in IDLE ----
  logic            w_is_div, w_a_signed, w_b_signed, w_sa, w_sb, w_neg_start;
  logic [XLEN-1:0] w_abs_a, w_abs_b;
  logic            w_accept, w_fast;
  logic [XLEN-1:0] w_fast_res;

  assign w_is_div    = funct3[2];
  assign w_a_signed  = w_is_div ? ~funct3[0] : (funct3 != 3'b011);
  assign w_b_signed  = w_is_div ? ~funct3[0] : ~funct3[1];
  assign w_sa        = w_a_signed & opa[XLEN-1];
  assign w_sb        = w_b_signed & opb[XLEN-1];
  assign w_abs_a     = w_sa ? -opa : opa;
  assign w_abs_b     = w_sb ? -opb : opb;
  // Remainder takes the dividend's sign; products and quotients the XOR.
  assign w_neg_start = (w_is_div & funct3[1]) ? w_sa : (w_sa ^ w_sb);
  assign w_accept    = (r_state == C_IDLE) & start & ~flush;

  always_comb begin
    w_fast     = 1'b0;
    w_fast_res = '0;
    if (w_is_div && (opb == '0)) begin
      w_fast     = 1'b1;
      w_fast_res = funct3[1] ? opa : '1;
    end else if (w_is_div && !funct3[0] && (opa == C_MIN) && (opb == '1)) begin
      w_fast     = 1'b1;
      w_fast_res = funct3[1] ? '0 : C_MIN;
    end
`ifdef MDU_EARLY_OUT_EN
    else if (!w_is_div && ((opa == '0) || (opb == '0))) begin
      w_fast     = 1'b1;
      w_fast_res = '0;
    end else if (w_is_div && (w_abs_a < w_abs_b)) begin
      w_fast     = 1'b1;
      w_fast_res = funct3[1] ? opa : '0;
    end
`endif
  end

  // ---- iteration datapath: hi half = partial product / remainder ----
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_step, w_div_step;
  logic [XLEN-1:0]   w_rem_sh, w_diff;
  logic              w_ge;

  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_div};
  assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]}
                               : {1'b0, r_acc[2*XLEN-1:1]};

  // A set remainder MSB means the shifted value already exceeds any divisor.
  assign w_rem_sh   = {r_acc[2*XLEN-2:XLEN], r_acc[XLEN-1]};
  assign w_ge       = r_acc[2*XLEN-1] | (w_rem_sh >= r_div);
  assign w_diff     = w_rem_sh - r_div;
  assign w_div_step = w_ge ? {w_diff, r_acc[XLEN-2:0], 1'b1}
                           : {r_acc[2*XLEN-2:0], 1'b0};

  // ---- sign correction and result selection ----
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_q_fix, w_r_fix, w_fix_res;

  assign w_prod_fix = r_neg ? -r_acc : r_acc;
  assign w_q_fix    = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_r_fix    = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix_res = w_r_fix;
    case (r_op)
      3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         w_fix_res = w_q_fix;
      default:                w_fix_res = w_r_fix;
    endcase
  end

  // ---- FSM ----
  always_ff @(posedge clk) begin
    if (rst) r_state <= C_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = C_IDLE;
    end else begin
      case (r_state)
        C_IDLE:  if (start) w_next = w_fast ? C_DONE : C_CALC;
        C_CALC:  if (r_cnt == CNT_W'(1)) w_next = C_FIX;
        C_FIX:   w_next = C_DONE;
        default: w_next = C_IDLE;
      endcase
    end
  end

  logic w_busy;
  always_comb begin
    w_busy = (r_state == C_CALC) || (r_state == C_FIX);
    busy   = w_busy;
    stall  = w_accept | w_busy;
    valid  = (r_state == C_DONE);
    result = r_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_div    <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (!flush) begin
      case (r_state)
        C_IDLE: if (start) begin
          r_op  <= funct3;
          r_neg <= w_neg_start;
          r_div <= w_abs_b;
          r_acc <= {{XLEN{1'b0}}, w_abs_a};
          r_cnt <= CNT_W'(XLEN);
          if (w_fast) r_result <= w_fast_res;
        end
        C_CALC: begin
          r_acc <= r_op[2] ? w_div_step : w_mul_step;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        C_FIX:   r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
